// File: rtl/wb_ram_slave.sv
// rtl/wb_ram_slave.sv - Wishbone classic RAM slave with programmable wait states
// Optional out-of-range error termination: define WB_RAM_SLAVE_ERR_EN.
module wb_ram_slave #(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    output logic [31:0]       o_wb_dat,
    output logic              o_wb_ack,
    output logic              o_wb_err
);

    localparam int IDX_W               = ADDR_W - 2;
    localparam int RAM_AW              = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS_CNT      = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdat_q, wdat_d;
    logic [3:0]         sel_q, sel_d;
    logic               ack_q, ack_d;
    logic [31:0]        rdat_q, rdat_d;
`ifdef WB_RAM_SLAVE_ERR_EN
    logic               err_q, err_d;
`endif

    logic [31:0]        ram [0:DEPTH-1];
    logic               req;
    logic               in_range;
    logic               ram_we;
    logic [RAM_AW-1:0]  ram_idx;
    logic [31:0]        ram_rd;

    // Byte offset bits never select anything in a word-organised RAM.
    logic               unused_adr_lsb;
    assign unused_adr_lsb = ^i_wb_adr[1:0];

    assign req      = i_wb_cyc & i_wb_stb;
    assign in_range = (32'(idx_q) < 32'(DEPTH));
    assign ram_idx  = idx_q[RAM_AW-1:0];
    assign ram_rd   = ram[ram_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = i_wb_we;
                    idx_d   = i_wb_adr[ADDR_W-1:2];
                    wdat_d  = i_wb_dat;
                    sel_d   = i_wb_sel;
                    cnt_d   = WS_CNT;
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Terminations are registered, so the access and the ack share the edge leaving RESP.
    always_comb begin
        ack_d  = 1'b0;
        rdat_d = rdat_q;
        ram_we = 1'b0;
`ifdef WB_RAM_SLAVE_ERR_EN
        err_d  = 1'b0;
`endif
        if (state_q == S_RESP) begin
            ram_we = we_q & in_range;
`ifdef WB_RAM_SLAVE_ERR_EN
            ack_d = in_range;
            err_d = ~in_range;
            if (!we_q && in_range) begin
                rdat_d = ram_rd;
            end
`else
            ack_d = 1'b1;
            if (!we_q) begin
                rdat_d = in_range ? ram_rd : 32'h0;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
`ifdef WB_RAM_SLAVE_ERR_EN
            err_q  <= 1'b0;
`endif
        end else begin
            ack_q  <= ack_d;
            rdat_q <= rdat_d;
`ifdef WB_RAM_SLAVE_ERR_EN
            err_q  <= err_d;
`endif
        end
    end

    // RAM contents survive reset; a reset on the RESP edge still cancels the write.
    always_ff @(posedge i_clk) begin
        if (ram_we && !i_rst) begin
            for (int n = 0; n < 4; n++) begin
                if (sel_q[n]) begin
                    ram[ram_idx][8*n +: 8] <= wdat_q[8*n +: 8];
                end
            end
        end
    end

    assign o_wb_dat = rdat_q;
    assign o_wb_ack = ack_q;
`ifdef WB_RAM_SLAVE_ERR_EN
    assign o_wb_err = err_q;
`else
    assign o_wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb/tb_wb_ram_slave.sv - randomized bench for wb_ram_slave against a word-array model
module tb_wb_ram_slave;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic [11:0] adr  [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel  [2];
    logic [31:0] rdat [2];
    logic        ack  [2];
    logic        err  [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] model    [2][1024];
    logic [31:0] last_dat [2];

    wb_ram_slave #(.ADDR_W(12), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .i_clk(clk), .i_rst(rst[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]),
        .i_wb_we(we[0]), .i_wb_adr(adr[0]), .i_wb_dat(wdat[0]), .i_wb_sel(sel[0]),
        .o_wb_dat(rdat[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0])
    );

    wb_ram_slave #(.ADDR_W(12), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
        .i_clk(clk), .i_rst(rst[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]),
        .i_wb_we(we[1]), .i_wb_adr(adr[1]), .i_wb_dat(wdat[1]), .i_wb_sel(sel[1]),
        .o_wb_dat(rdat[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1])
    );

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 0) ? 1024 : 16;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int i, input bit w, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        int idx;
        int k;
        bit oor;
        bit seen;
        bit exp_ack;
        bit exp_err;
        idx = int'(a[11:2]);
        oor = (idx >= depth_of(i));
`ifdef WB_RAM_SLAVE_ERR_EN
        exp_ack = !oor;
        exp_err = oor;
`else
        exp_ack = 1'b1;
        exp_err = 1'b0;
`endif
        if (w && !oor) begin
            for (int n = 0; n < 4; n++) begin
                if (s[n]) model[i][idx][8*n +: 8] = d[8*n +: 8];
            end
        end
        if (!w) begin
            if (!oor) begin
                last_dat[i] = model[i][idx];
            end else begin
`ifndef WB_RAM_SLAVE_ERR_EN
                last_dat[i] = 32'h0;
`endif
            end
        end
        @(negedge clk);
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; wdat[i] = d; sel[i] = s;
        @(posedge clk);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 30) begin
            @(posedge clk);
            #1;
            k++;
            if (ack[i] || err[i]) begin
                seen = 1'b1;
            end else begin
                we[i]   = 1'($urandom);
                adr[i]  = 12'($urandom);
                wdat[i] = $urandom;
                sel[i]  = 4'($urandom);
            end
        end
        check_eq($sformatf("latency[%0d]", i), 32'(k), 32'(1 + ws_of(i)));
        check_eq($sformatf("ack[%0d]", i), 32'(ack[i]), 32'(exp_ack));
        check_eq($sformatf("err[%0d]", i), 32'(err[i]), 32'(exp_err));
        check_eq($sformatf("rdat[%0d]@%03h", i, a), rdat[i], last_dat[i]);
        cyc[i] = 1'b0;
        stb[i] = 1'b0;
        @(posedge clk);
        #1;
        check_eq($sformatf("pulse_end[%0d]", i), 32'({ack[i], err[i]}), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int idx;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            adr[i] = '0; wdat[i] = '0; sel[i] = '0; last_dat[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("reset_ack[%0d]", i), 32'(ack[i]), 32'h0);
            check_eq($sformatf("reset_err[%0d]", i), 32'(err[i]), 32'h0);
            check_eq($sformatf("reset_dat[%0d]", i), rdat[i], 32'h0);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int wd = 0; wd < 64; wd++) xfer(0, 1'b1, {10'(wd), 2'b00}, $urandom, 4'hF);
        for (int wd = 0; wd < 16; wd++) xfer(1, 1'b1, {10'(wd), 2'b00}, $urandom, 4'hF);

        xfer(0, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 12'h004, 32'h0, 4'h0);
        check_eq("read_deadbeef", rdat[0], 32'hDEADBEEF);

        xfer(0, 1'b1, 12'h010, 32'h11223344, 4'hF);
        xfer(0, 1'b1, 12'h010, 32'hAABBCCDD, 4'h5);
        xfer(0, 1'b0, 12'h010, 32'h0, 4'hF);
        check_eq("byte_lanes", rdat[0], 32'h11BB33DD);

        xfer(1, 1'b1, 12'h020, 32'h0, 4'hF);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 12'h020;
        wdat[1] = 32'h12345678; sel[1] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cyc[1] = 1'b0;
        stb[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check_eq("abort_quiet", 32'({ack[1], err[1]}), 32'h0);
        end
        xfer(1, 1'b0, 12'h020, 32'h0, 4'h0);
        check_eq("abort_not_written", rdat[1], 32'h0);

        xfer(1, 1'b0, 12'h040, 32'h0, 4'hF);
`ifndef WB_RAM_SLAVE_ERR_EN
        check_eq("oor_read_zero", rdat[1], 32'h0);
`endif
        xfer(1, 1'b1, 12'h040, 32'hFFFFFFFF, 4'hF);
        xfer(1, 1'b0, 12'h000, 32'h0, 4'h0);

        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 12'h024;
        wdat[1] = 32'hCAFEF00D; sel[1] = 4'hF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        cyc[1] = 1'b0;
        stb[1] = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midreset_ack", 32'(ack[1]), 32'h0);
        check_eq("midreset_err", 32'(err[1]), 32'h0);
        check_eq("midreset_dat", rdat[1], 32'h0);
        @(negedge clk);
        rst[1] = 1'b0;
        last_dat[1] = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_eq("midreset_quiet", 32'({ack[1], err[1]}), 32'h0);
        end
        xfer(1, 1'b0, 12'h024, 32'h0, 4'h0);

        for (int t = 0; t < 150; t++) begin
            idx = $urandom_range(0, 63);
            xfer(0, 1'($urandom), {10'(idx), 2'($urandom)}, $urandom, 4'($urandom));
        end
        for (int t = 0; t < 150; t++) begin
            idx = ($urandom % 2 == 0) ? $urandom_range(0, 15) : $urandom_range(16, 1023);
            xfer(1, 1'($urandom), {10'(idx), 2'($urandom)}, $urandom, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
